// File: rtl/load_store_unit_if.sv
// Command and memory bus bundle for the load/store unit.
// master = execute stage + memory, slave = the LSU itself.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);

  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_r_enable;
  logic [31:0]       mem_rdata;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;

  modport master (
    output start,
    output is_store,
    output funct3,
    output addr,
    output wdata,
    input  busy,
    input  done,
    input  err,
    input  rdata,
    input  mem_addr,
    input  mem_r_enable,
    output mem_rdata,
    input  mem_wdata,
    input  mem_wmask
  );

  modport slave (
    input  start,
    input  is_store,
    input  funct3,
    input  addr,
    input  wdata,
    output busy,
    output done,
    output err,
    output rdata,
    output mem_addr,
    output mem_r_enable,
    input  mem_rdata,
    output mem_wdata,
    output mem_wmask
  );

endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access per command against a
// single-port memory with one-cycle read latency.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR,
    DONE
  } state_t;

  state_t            state;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] maddr_q;
  logic              ren_q;
  logic [31:0]       mwdata_q;
  logic [3:0]        wmask_q;

  logic              is_b;
  logic              is_h;
  logic              is_w;
  logic              bad_ld;
  logic              bad_st;
  logic              misal;
  logic              reject;
  logic [ADDR_W-1:0] waddr;

  logic [31:0]       st_data;
  logic [3:0]        st_mask;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.rdata        = rdata_q;
  assign bus.mem_addr     = maddr_q;
  assign bus.mem_r_enable = ren_q;
  assign bus.mem_wdata    = mwdata_q;
  assign bus.mem_wmask    = wmask_q;

  assign waddr = {bus.addr[ADDR_W-1:2], 2'b00};

  // Classify the incoming command: width, legality, alignment.
  always_comb begin
    is_b   = (bus.funct3[1:0] == 2'b00);
    is_h   = (bus.funct3[1:0] == 2'b01);
    is_w   = (bus.funct3 == 3'b010);
    bad_ld = (bus.funct3 == 3'b011)
          || (bus.funct3 == 3'b110)
          || (bus.funct3 == 3'b111);
    bad_st = (bus.funct3 > 3'b010);
    misal  = (is_h && bus.addr[0])
          || (is_w && (bus.addr[1:0] != 2'b00));
    reject = (bus.is_store ? bad_st : bad_ld)
          || misal;
  end

  // Place store data on its byte lanes and build the mask.
  always_comb begin
    st_data = bus.wdata;
    st_mask = 4'b1111;
    unique case (1'b1)
      is_b: begin
        st_data = {24'd0, bus.wdata[7:0]}
               << {bus.addr[1:0], 3'b000};
        st_mask = 4'b0001 << bus.addr[1:0];
      end
      is_h: begin
        st_data = bus.addr[1]
                ? {bus.wdata[15:0], 16'd0}
                : {16'd0, bus.wdata[15:0]};
        st_mask = bus.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = bus.wdata;
        st_mask = 4'b1111;
      end
    endcase
  end

  // Pick the addressed lane from the read word and extend it.
  always_comb begin
    unique case (off_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus.mem_rdata[31:16]
                       : bus.mem_rdata[15:0];
    unique case (1'b1)
      (f3_q == 3'b000):
        ld_val = {{24{ld_byte[7]}}, ld_byte};
      (f3_q == 3'b100):
        ld_val = {24'd0, ld_byte};
      (f3_q == 3'b001):
        ld_val = {{16{ld_half[15]}}, ld_half};
      (f3_q == 3'b101):
        ld_val = {16'd0, ld_half};
      default:
        ld_val = bus.mem_rdata;
    endcase
  end

  // Control FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      maddr_q  <= '0;
      ren_q    <= 1'b0;
      mwdata_q <= 32'd0;
      wmask_q  <= 4'd0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ren_q    <= 1'b0;
      wmask_q  <= 4'd0;
      mwdata_q <= 32'd0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            f3_q   <= bus.funct3;
            off_q  <= bus.addr[1:0];
            busy_q <= 1'b1;
            if (reject) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (bus.is_store) begin
              state    <= WR;
              maddr_q  <= waddr;
              wmask_q  <= st_mask;
              mwdata_q <= st_data;
            end else begin
              state   <= RD_REQ;
              maddr_q <= waddr;
              ren_q   <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          state <= RD_DATA;
        end
        RD_DATA: begin
          rdata_q <= ld_val;
          done_q  <= 1'b1;
          state   <= DONE;
        end
        WR: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's single-port synchronous memory interface. The memory answers reads one clock after the request.
- Accepts one load or store per command from the execute stage.
- Loads: issues a word-aligned read, extracts the byte/half/word, and sign- or zero-extends it.
- Stores: drives shifted write data and a byte write mask.
- Rejects misaligned accesses and illegal widths without touching memory.

Parameters:
- ADDR_W, 32, byte-address width presented to memory.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  ADDR_W  byte address of the access.
- wdata  input  32  store data, right-aligned.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = access rejected.
- rdata  output  32  extended load result; holds until the next load completes.
- mem_addr  output  ADDR_W  word-aligned address; bits [1:0] always 0.
- mem_r_enable  output  1  read strobe.
- mem_rdata  input  32  memory read data, valid the cycle after mem_r_enable.
- mem_wdata  output  32  lane-shifted store data.
- mem_wmask  output  4  byte write enables; bit i writes byte lane i (bits [8i+7:8i]).

Behaviour:
- States: IDLE, RD_REQ, RD_DATA, WR, DONE.
- Reset (synchronous, any state): state = IDLE, busy = 0, done = 0, err = 0, rdata = 0, mem_addr = 0, mem_r_enable = 0, mem_wdata = 0, mem_wmask = 0.
- IDLE with start = 1: latch is_store, funct3, addr, wdata, then check the command.
  - Illegal: load funct3 in {011, 110, 111}, or store funct3 > 010.
  - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - Illegal or misaligned: go to DONE with err = 1.
  - Otherwise: load -> RD_REQ, store -> WR.
- IDLE with start = 0: stay in IDLE.
- start while busy is ignored; no queueing.
- RD_REQ: mem_r_enable = 1, mem_addr = {addr[ADDR_W-1:2], 2'b00}. Next state RD_DATA.
- RD_DATA: mem_rdata is valid.
  - Select lane by addr[1:0] for bytes, or addr[1] for halves.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Register the result into rdata. Next state DONE.
- WR: one cycle. mem_addr is word-aligned.
  - B: mem_wdata = wdata[7:0] << (8*addr[1:0]); mem_wmask = 0001 << addr[1:0].
  - H: mem_wdata = wdata[15:0] << (16*addr[1]); mem_wmask = 0011 or 1100.
  - W: mem_wdata = wdata; mem_wmask = 1111.
  - Next state DONE.
- DONE: done = 1 for exactly one cycle, with err valid. Next state IDLE.
  - A new start is accepted on the following cycle.
- Strobes: mem_r_enable and mem_wmask are nonzero only in RD_REQ and WR respectively. At all other times mem_wmask = 0, and mem_wdata has no meaning while mem_wmask = 0.
- Rejected commands never assert mem_r_enable or mem_wmask. rdata keeps its previous value after a rejected command or a store.
- Latency from the start cycle T:
  - load: mem_r_enable at T+1, done at T+3.
  - store: mem_wmask at T+1, done at T+2.
  - rejected: done at T+1.
- Reset during RD_REQ, RD_DATA or WR aborts the access. No strobe and no done pulse appear in the cycle after reset.

Test Plan:
- Memory model with word 100 = 0x04030201 and word 103 = 0xFF0F0E0D.
  - LW addr 400 -> mem_r_enable at T+1 with mem_addr = 400; done at T+3, rdata = 0x04030201, err = 0.
  - LB addr 415 -> rdata = 0xFFFFFFFF; LBU addr 415 -> 0x000000FF; LB addr 401 -> 0x00000002.
  - LH addr 414 -> rdata = 0xFFFFFF0F; LHU addr 414 -> 0x0000FF0F; LH addr 412 -> 0x00000E0D.
- SB addr 401, wdata 0x000000AB -> at T+1 mem_addr = 400, mem_wmask = 0010, mem_wdata = 0x0000AB00; done at T+2; rdata unchanged.
- SH addr 402, wdata 0xDEAD1234 -> mem_wmask = 1100, mem_wdata = 0x12340000; SW addr 404, wdata 0xCAFEF00D -> mem_wmask = 1111, mem_wdata = 0xCAFEF00D.
- Rejections:
  - LW addr 402, LH addr 401, load funct3 = 011, store funct3 = 100 -> done and err = 1 at T+1.
  - mem_r_enable and mem_wmask stay 0 throughout; rdata unchanged.
- Control corner cases:
  - start pulses at T+1 and T+2 during a load are ignored, and exactly one done is seen.
  - reset asserted in RD_DATA -> IDLE next cycle, all outputs at reset values, no done.
  - A new LW issued the cycle after done is accepted.
